// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester RAM data-port arbiter: FSM states,
// latched request record and the sub-word store merge helper.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            be;
    } mem_req_t;

    // Lane i takes the new byte when be[i] is set, otherwise keeps the RAM byte.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and RAM-port bundle for mem_arbiter; master = requesters + RAM
// model side, slave = the arbiter.
interface mem_arb_if #(parameter int ADDR_W = 32);

    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic [3:0]        m0_be,    m1_be;
    logic              m0_gnt,   m1_gnt;
    logic              m0_done,  m1_done;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_rd;
    logic              ram_we;
    logic [31:0]       ram_wd;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output ram_rd,
        input  m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
        input  ram_addr, ram_we, ram_wd
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  ram_rd,
        output m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
        output ram_addr, ram_we, ram_wd
    );

endinterface

// File: rtl/mem_arb_select.sv
// Two-way grant logic. MEM_ARB_ROUND_ROBIN_EN selects round-robin with a
// last-grant pointer; otherwise requester 0 has fixed priority.
module mem_arb_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last;  // id of the most recent grant; reset to 1 so requester 0 goes first

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11)
                gnt = last ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (en)
            gnt = req[0] ? 2'b01 : req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto the RAM data port; sub-word stores become
// read-merge-write. Optional MEM_ARB_ROUND_ROBIN_EN enables round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic     clk,
    input logic     rst,
    mem_arb_if.slave bus
);

    state_e             state, nxt;
    mem_req_t           req_q, m0_r, m1_r;
    logic               owner;
    logic [31:0]        merged_q;
    logic [1:0]         req, gnt, done_q;
    logic [1:0][31:0]   rdata_q;
    logic               partial;

    assign req  = {bus.m1_req, bus.m0_req};
    assign m0_r = '{we: bus.m0_we, addr: MEM_ADDR_W'(bus.m0_addr & ~ADDR_W'(3)),
                    wdata: bus.m0_wdata, be: bus.m0_be};
    assign m1_r = '{we: bus.m1_we, addr: MEM_ADDR_W'(bus.m1_addr & ~ADDR_W'(3)),
                    wdata: bus.m1_wdata, be: bus.m1_be};

    mem_arb_select u_sel (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (req),
        .en  (state == IDLE),
        .gnt (gnt)
    );

    assign partial = (req_q.be != 4'h0) && (req_q.be != 4'hF);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (|gnt) nxt = ACCESS;
            ACCESS:  nxt = (req_q.we && partial) ? WRITE : IDLE;
            WRITE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_addr = '0;
        bus.ram_we   = 1'b0;
        bus.ram_wd   = '0;
        case (state)
            ACCESS: begin
                bus.ram_addr = ADDR_W'(req_q.addr);
                if (req_q.we && req_q.be == 4'hF) begin
                    bus.ram_we = 1'b1;
                    bus.ram_wd = req_q.wdata;
                end
            end
            WRITE: begin
                bus.ram_addr = ADDR_W'(req_q.addr);
                bus.ram_we   = 1'b1;
                bus.ram_wd   = merged_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= '0;
            owner    <= 1'b0;
            merged_q <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state  <= nxt;
            done_q <= '0;
            if (state == IDLE && |gnt) begin
                owner <= gnt[1];
                req_q <= gnt[1] ? m1_r : m0_r;
            end
            if (state == ACCESS) begin
                if (!req_q.we)
                    rdata_q[owner] <= bus.ram_rd;
                // done lands in the IDLE cycle following the last RAM cycle
                if (nxt == IDLE)
                    done_q[owner] <= 1'b1;
                else
                    merged_q <= byte_merge(bus.ram_rd, req_q.wdata, req_q.be);
            end
            if (state == WRITE)
                done_q[owner] <= 1'b1;
        end
    end

    assign bus.m0_gnt   = gnt[0];
    assign bus.m1_gnt   = gnt[1];
    assign bus.m0_done  = done_q[0];
    assign bus.m1_done  = done_q[1];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_rdata = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, random traffic
// against a word-level memory model, contention and reset-abort sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(32)) bus ();
    mem_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    assign bus.ram_rd = mem[bus.ram_addr[9:2]];
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_wd;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd_model [2];
    int rr_last = 1;

    typedef struct {
        int          p;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          lat;
        int          we_at;
        logic [31:0] val;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_be = be;
        end else begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_be = be;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.m0_gnt : bus.m1_gnt;
    endfunction
    function automatic logic done_of(input int p);
        return (p == 0) ? bus.m0_done : bus.m1_done;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
    endfunction

    // Winner when both are pending, from the arbitration rule alone.
    function automatic int exp_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (rr_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_txn(input int p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int exp_lat,
                          input int exp_we_at, input logic [31:0] exp_val,
                          input logic [31:0] exp_addr, input string nm);
        int cyc, done_at, we_at, we_cnt;
        logic [31:0] wd_seen, addr_seen, idle_addr;
        drive(p, 1, we, addr, wd, be);
        #1;
        cyc = 0;
        while (!gnt_of(p) && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check({nm, " gnt"}, {31'b0, gnt_of(p)}, 32'd1);
        check({nm, " other gnt"}, {31'b0, gnt_of(1 - p)}, 32'd0);
        if (!gnt_of(p)) begin drive(p, 0, 0, 0, 0, 0); return; end
        rr_last = p;
        done_at = 0; we_at = 0; we_cnt = 0; wd_seen = 0; addr_seen = 0; idle_addr = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin drive(p, 0, 0, 0, 0, 0); addr_seen = bus.ram_addr; end
            if (bus.ram_we) begin we_cnt++; we_at = k; wd_seen = bus.ram_wd; end
            if (done_of(p) && done_at == 0) done_at = k;
            if (k == 4) idle_addr = bus.ram_addr;
        end
        check({nm, " done lat"}, done_at, exp_lat);
        check({nm, " ram_we count"}, we_cnt, (exp_we_at != 0) ? 1 : 0);
        check({nm, " ram_we cycle"}, we_at, exp_we_at);
        check({nm, " ram_addr"}, addr_seen, exp_addr);
        check({nm, " idle ram_addr"}, idle_addr, 32'h0);
        if (exp_we_at != 0) begin
            check({nm, " ram_wd"}, wd_seen, exp_val);
            ref_mem[exp_addr[9:2]] = exp_val;
        end
        if (!we) begin
            check({nm, " rdata"}, rdata_of(p), exp_val);
            rd_model[p] = exp_val;
        end
        check({nm, " other rdata hold"}, rdata_of(1 - p), rd_model[1 - p]);
    endtask

    initial begin
        int w, l, idx, lat, wat;
        logic [31:0] a, d, old, mask, val;
        logic [3:0] be;
        bit we;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1000_0000 + i * 32'h0101;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF;  ref_mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;  ref_mem[8] = 32'h11223344;
        rd_model[0] = 0; rd_model[1] = 0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        vecs[0] = '{0, 0, 32'h10, 32'h0,        4'h0, 2, 0, 32'hDEADBEEF, 32'h10};
        vecs[1] = '{1, 1, 32'h20, 32'hAABBCCDD, 4'h5, 3, 2, 32'h11BB33DD, 32'h20};
        vecs[2] = '{0, 0, 32'h20, 32'h0,        4'h0, 2, 0, 32'h11BB33DD, 32'h20};
        vecs[3] = '{1, 1, 32'h13, 32'h12345678, 4'h0, 2, 0, 32'h0,        32'h10};
        vecs[4] = '{1, 0, 32'h13, 32'h0,        4'h0, 2, 0, 32'hDEADBEEF, 32'h10};
        vecs[5] = '{0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 2, 1, 32'hCAFEF00D, 32'h30};
        vecs[6] = '{1, 0, 32'h30, 32'h0,        4'h0, 2, 0, 32'hCAFEF00D, 32'h30};
        vecs[7] = '{0, 1, 32'h30, 32'h00000099, 4'h8, 3, 2, 32'h00FEF00D, 32'h30};
        vecs[8] = '{0, 0, 32'h31, 32'h0,        4'h0, 2, 0, 32'h00FEF00D, 32'h30};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
        check("rst done", {30'b0, bus.m1_done, bus.m0_done}, 32'h0);
        check("rst rdata0", bus.m0_rdata, 32'h0);
        check("rst rdata1", bus.m1_rdata, 32'h0);
        check("rst ram", {31'b0, bus.ram_we} | bus.ram_addr | bus.ram_wd, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_txn(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be, vecs[i].lat,
                   vecs[i].we_at, vecs[i].val, vecs[i].eaddr, $sformatf("vec%0d", i));

        // Random traffic against the word-level model
        for (int n = 0; n < 40; n++) begin
            a   = 32'h80 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            d   = $urandom;
            be  = 4'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            idx = int'(a[9:2]);
            old = ref_mem[idx];
            mask = lane_mask(be);
            if (we) begin
                val = (old & ~mask) | (d & mask);
                lat = (be != 4'h0 && be != 4'hF) ? 3 : 2;
                wat = (be == 4'h0) ? 0 : ((be == 4'hF) ? 1 : 2);
            end else begin
                val = old; lat = 2; wat = 0;
            end
            do_txn(int'($urandom_range(0, 1)), we, a, d, be, lat, wat, val,
                   {a[31:2], 2'b00}, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        // Contention: both request in the same cycle; loser is served back-to-back
        for (int r = 0; r < 4; r++) begin
            drive(0, 1, 0, 32'h40, 0, 0);
            drive(1, 1, 0, 32'h44, 0, 0);
            #1;
            w = exp_winner(); l = 1 - w;
            check($sformatf("cont%0d gnt", r), {30'b0, bus.m1_gnt, bus.m0_gnt}, (w == 0) ? 32'd1 : 32'd2);
            rr_last = w;
            @(posedge clk); #1;
            drive(w, 0, 0, 0, 0, 0);
            check($sformatf("cont%0d busy gnt", r), {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("cont%0d done w", r), {31'b0, done_of(w)}, 32'd1);
            check($sformatf("cont%0d gnt l", r), {31'b0, gnt_of(l)}, 32'd1);
            check($sformatf("cont%0d rdata w", r), rdata_of(w), ref_mem[16 + w]);
            rd_model[w] = ref_mem[16 + w];
            rr_last = l;
            @(posedge clk); #1;
            drive(l, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            check($sformatf("cont%0d done l", r), {31'b0, done_of(l)}, 32'd1);
            check($sformatf("cont%0d rdata l", r), rdata_of(l), ref_mem[16 + l]);
            rd_model[l] = ref_mem[16 + l];
        end

        // Reset during the WRITE cycle of a partial store
        drive(1, 1, 1, 32'h50, 32'hFFFFFFFF, 4'h3);
        #1;
        check("abort gnt", {31'b0, bus.m1_gnt}, 32'd1);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("abort in write", {31'b0, bus.ram_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort ram_we", {31'b0, bus.ram_we}, 32'd0);
        check("abort ram_addr", bus.ram_addr, 32'h0);
        check("abort ram_wd", bus.ram_wd, 32'h0);
        check("abort done", {30'b0, bus.m1_done, bus.m0_done}, 32'h0);
        check("abort rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
        rd_model[0] = 0; rd_model[1] = 0; rr_last = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("post-abort quiet%0d", k),
                  {29'b0, bus.ram_we, bus.m1_done, bus.m0_done}, 32'h0);
        end
        drive(0, 1, 0, 32'h50, 0, 0);
        drive(1, 1, 0, 32'h54, 0, 0);
        #1;
        check("post-abort gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("post-abort done0", {31'b0, bus.m0_done}, 32'd1);
        check("post-abort word", bus.m0_rdata, ref_mem[20]);
        check("post-abort ram word", mem[20], ref_mem[20]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
